// File: rtl/arbitro_pkg.sv
// rtl/arbitro_pkg.sv - shared types and constants for the data memory arbiter
package arbitro_pkg;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        ACESSO  = 2'd1,
        RETORNO = 2'd2
    } estado_t;

    localparam logic [1:0] DT_BYTE = 2'd0;
    localparam logic [1:0] DT_HALF = 2'd1;
    localparam logic [1:0] DT_WORD = 2'd2;

    localparam int REQ_CPU = 0;
    localparam int REQ_AUX = 1;

endpackage

// File: rtl/arbitro_rr2.sv
// rtl/arbitro_rr2.sv - combinational two-way round-robin picker
module arbitro_rr2 (
    input  logic [1:0] elig,
    input  logic       last_winner,
    output logic [1:0] win
);

    always_comb begin
        win = 2'b00;
        case (elig)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            // On a tie the requester that did not win last time goes first.
            2'b11:   win = last_winner ? 2'b01 : 2'b10;
            default: win = 2'b00;
        endcase
    end

endmodule

// File: rtl/arbitro_memoria_dados.sv
// rtl/arbitro_memoria_dados.sv - two-port arbiter/sequencer for the data memory; optional ARB_LOCK_EN
module arbitro_memoria_dados
    import arbitro_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [1:0]        dtype0,
    input  logic [1:0]        dtype1,
`ifdef ARB_LOCK_EN
    input  logic [1:0]        lock,
`endif
    output logic [1:0]        gnt,
    output logic [1:0]        rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_dtype,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);

    estado_t    state, state_nx;
    logic [1:0] elig;
    logic [1:0] win;
    logic       win_idx;
    logic       start;
    logic       last_winner;
    logic       lat_w;
    logic       lat_we;

`ifdef ARB_LOCK_EN
    logic lock_valid;
    logic lock_owner;

    always_comb begin
        elig = req;
        if (lock_valid)
            elig = req & (lock_owner ? 2'b10 : 2'b01);
    end
`else
    assign elig = req;
`endif

    arbitro_rr2 u_rr2 (
        .elig        (elig),
        .last_winner (last_winner),
        .win         (win)
    );

    assign win_idx = win[1];
    assign start   = (state == OCIOSO) && (|elig);

    always_comb begin
        state_nx = state;
        case (state)
            OCIOSO:  if (|elig) state_nx = ACESSO;
            ACESSO:  state_nx = lat_we ? OCIOSO : RETORNO;
            RETORNO: state_nx = OCIOSO;
            default: state_nx = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= OCIOSO;
        else
            state <= state_nx;
    end

    // The mem_* flops double as the latched operand copy, so they hold between accesses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt         <= 2'b00;
            rvalid      <= 2'b00;
            rdata       <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_dtype   <= 2'b00;
            mem_we      <= 1'b0;
            mem_re      <= 1'b0;
            last_winner <= 1'b1;
            lat_w       <= 1'b0;
            lat_we      <= 1'b0;
`ifdef ARB_LOCK_EN
            lock_valid  <= 1'b0;
            lock_owner  <= 1'b0;
`endif
        end else begin
            gnt    <= 2'b00;
            rvalid <= 2'b00;
            mem_we <= 1'b0;
            mem_re <= 1'b0;
            if (start) begin
                gnt         <= win;
                lat_w       <= win_idx;
                lat_we      <= we[win_idx];
                last_winner <= win_idx;
                mem_addr    <= win_idx ? addr1  : addr0;
                mem_wdata   <= win_idx ? wdata1 : wdata0;
                mem_dtype   <= win_idx ? dtype1 : dtype0;
                mem_we      <= we[win_idx];
                mem_re      <= !we[win_idx];
`ifdef ARB_LOCK_EN
                // Only the owner can win while locked, so this both takes and releases.
                lock_valid  <= lock[win_idx];
                lock_owner  <= win_idx;
`endif
            end
            if (state == ACESSO && !lat_we) begin
                rdata  <= mem_rdata;
                rvalid <= lat_w ? 2'b10 : 2'b01;
            end
        end
    end

endmodule

// File: tb/tb_arbitro_memoria_dados.sv
// tb/tb_arbitro_memoria_dados.sv - self-checking bench for arbitro_memoria_dados
module tb_arbitro_memoria_dados;
    import arbitro_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, we;
    logic [5:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic [1:0]  dtype0, dtype1;
`ifdef ARB_LOCK_EN
    logic [1:0]  lock;
`endif
    logic [1:0]  gnt, rvalid;
    logic [31:0] rdata, mem_wdata, mem_rdata;
    logic [5:0]  mem_addr;
    logic [1:0]  mem_dtype;
    logic        mem_we, mem_re;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    arbitro_memoria_dados #(.ADDR_W(6), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .dtype0(dtype0), .dtype1(dtype1),
`ifdef ARB_LOCK_EN
        .lock(lock),
`endif
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_dtype(mem_dtype),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    // Memory: synchronous write, data presented combinationally from the address.
    logic [31:0] mem [64];
    logic        preload = 1'b0;

    function automatic logic [31:0] pattern(input int a);
        return 32'hA5000000 ^ (a * 32'h00010203);
    endfunction

    always @(posedge clk) begin
        if (preload) begin
            for (int a = 0; a < 64; a++) mem[a] <= pattern(a);
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = 2'b00; we = 2'b00;
`ifdef ARB_LOCK_EN
        lock = 2'b00;
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        who;
        logic        wr;
        logic [5:0]  a;
        logic [31:0] d;
        logic [1:0]  dt;
        logic [1:0]  e_gnt;
        logic [31:0] e_rdata;
    } vec_t;

    typedef struct {
        logic [1:0]  gnt;
        logic [1:0]  rvalid;
        logic        mwe;
        logic        mre;
        logic [5:0]  a;
        logic [31:0] d;
        logic [1:0]  dt;
        logic [31:0] rd;
    } exp_t;

    vec_t tbl [6];
    exp_t exp_q [$];

    logic        p_pend [2];
    logic        p_we   [2];
    logic [5:0]  p_addr [2];
    logic [31:0] p_data [2];
    logic [1:0]  p_dt   [2];
    logic [31:0] ref_mem [64];

    initial begin
        logic [1:0] gs [$];
        logic [1:0] prev;
        int         cnt1;
        int         last;
        int         w;
        exp_t       e;
        exp_t       idle_e;

        wdata0 = '0; wdata1 = '0; addr0 = '0; addr1 = '0;
        dtype0 = DT_WORD; dtype1 = DT_WORD;
        do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_gnt", {30'd0, gnt}, 0);
        chk("rst_rvalid", {30'd0, rvalid}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_mem_addr", {26'd0, mem_addr}, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_strobes", {30'd0, mem_we, mem_re}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single transactions, one at a time.
        tbl[0] = '{1'b0, 1'b1, 6'h05, 32'hDEADBEEF, DT_WORD, 2'b01, 32'h0};
        tbl[1] = '{1'b1, 1'b1, 6'h0A, 32'h12345678, DT_WORD, 2'b10, 32'h0};
        tbl[2] = '{1'b1, 1'b0, 6'h0A, 32'h0,        DT_WORD, 2'b10, 32'h12345678};
        tbl[3] = '{1'b0, 1'b0, 6'h05, 32'h0,        DT_HALF, 2'b01, 32'hDEADBEEF};
        tbl[4] = '{1'b0, 1'b1, 6'h3F, 32'h000000C3, DT_BYTE, 2'b01, 32'h0};
        tbl[5] = '{1'b1, 1'b0, 6'h3F, 32'h0,        DT_BYTE, 2'b10, 32'h000000C3};
        for (int i = 0; i < 6; i++) begin
            req = tbl[i].who ? 2'b10 : 2'b01;
            we  = {tbl[i].wr, tbl[i].wr};
            if (tbl[i].who) begin
                addr1 = tbl[i].a; wdata1 = tbl[i].d; dtype1 = tbl[i].dt;
            end else begin
                addr0 = tbl[i].a; wdata0 = tbl[i].d; dtype0 = tbl[i].dt;
            end
            @(negedge clk);
            chk($sformatf("v%0d_gnt", i), {30'd0, gnt}, {30'd0, tbl[i].e_gnt});
            chk($sformatf("v%0d_strobes", i), {30'd0, mem_we, mem_re}, {30'd0, tbl[i].wr, !tbl[i].wr});
            chk($sformatf("v%0d_addr", i), {26'd0, mem_addr}, {26'd0, tbl[i].a});
            chk($sformatf("v%0d_dtype", i), {30'd0, mem_dtype}, {30'd0, tbl[i].dt});
            if (tbl[i].wr) chk($sformatf("v%0d_wdata", i), mem_wdata, tbl[i].d);
            req = 2'b00;
            @(negedge clk);
            if (!tbl[i].wr) begin
                chk($sformatf("v%0d_rvalid", i), {30'd0, rvalid}, {30'd0, tbl[i].e_gnt});
                chk($sformatf("v%0d_rdata", i), rdata, tbl[i].e_rdata);
                @(negedge clk);
            end
            chk($sformatf("v%0d_idle", i), {28'd0, gnt, mem_we, mem_re}, 0);
        end

        // Continuous tie from reset alternates, requester 0 first.
        do_reset();
        req = 2'b11; we = 2'b11; addr0 = 6'h01; addr1 = 6'h02;
        prev = 2'b00;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("tie_back_to_back", {31'd0, (prev != 0) && (gnt != 0)}, 0);
            if (gnt != 0) gs.push_back(gnt);
            prev = gnt;
        end
        req = 2'b00;
        chk("tie_count", gs.size(), 4);
        for (int k = 0; k < gs.size() && k < 4; k++)
            chk($sformatf("tie_order%0d", k), {30'd0, gs[k]}, (k % 2 == 0) ? 1 : 2);
        @(negedge clk);

        // Operands change right after the grant edge.
        req = 2'b01; we = 2'b01; addr0 = 6'h03; wdata0 = 32'h0BADF00D;
        @(posedge clk);
        #1 addr0 = 6'h3F; wdata0 = 32'h0;
        @(negedge clk);
        chk("opchg_gnt", {30'd0, gnt}, 1);
        chk("opchg_addr", {26'd0, mem_addr}, 6'h03);
        chk("opchg_wdata", mem_wdata, 32'h0BADF00D);
        req = 2'b00;
        @(negedge clk);

        // Reset in the middle of a read.
        req = 2'b10; we = 2'b00; addr1 = 6'h0A;
        @(negedge clk);
        chk("midrst_re_before", {31'd0, mem_re}, 1);
        rst_n = 1'b0; req = 2'b00;
        #1;
        chk("midrst_zero", {26'd0, gnt, rvalid, mem_we, mem_re}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("midrst_no_rvalid", {30'd0, rvalid}, 0);
        end
        req = 2'b11; we = 2'b11;
        @(negedge clk);
        chk("midrst_tie_gnt", {30'd0, gnt}, 1);
        req = 2'b00;
        @(negedge clk);

`ifdef ARB_LOCK_EN
        do_reset();
        gs.delete();
        cnt1 = 0;
        req = 2'b10; we = 2'b11; lock = 2'b10; addr1 = 6'h10; addr0 = 6'h20;
        for (int c = 0; c < 20 && gs.size() < 4; c++) begin
            @(negedge clk);
            if (gnt != 0) gs.push_back(gnt);
            if (gnt[1]) begin
                cnt1++;
                req[0] = 1'b1;
                lock[1] = (cnt1 < 2);
                if (cnt1 == 3) req[1] = 1'b0;
            end
            if (gnt[0]) req[0] = 1'b0;
        end
        req = 2'b00; lock = 2'b00;
        chk("lock_count", gs.size(), 4);
        for (int k = 0; k < gs.size() && k < 4; k++)
            chk($sformatf("lock_order%0d", k), {30'd0, gs[k]}, (k < 3) ? 2 : 1);
        @(negedge clk);
        @(negedge clk);
`endif

        // Randomized traffic against a transaction-level schedule model.
        do_reset();
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
        for (int a = 0; a < 64; a++) ref_mem[a] = pattern(a);
        last = 1;
        idle_e = '{2'b00, 2'b00, 1'b0, 1'b0, 6'h0, 32'h0, 2'b00, 32'h0};
        for (int i = 0; i < 2; i++) p_pend[i] = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : idle_e;
            chk("rnd_gnt", {30'd0, gnt}, {30'd0, e.gnt});
            chk("rnd_rvalid", {30'd0, rvalid}, {30'd0, e.rvalid});
            chk("rnd_strobes", {30'd0, mem_we, mem_re}, {30'd0, e.mwe, e.mre});
            if (e.gnt != 0) begin
                chk("rnd_addr", {26'd0, mem_addr}, {26'd0, e.a});
                chk("rnd_dtype", {30'd0, mem_dtype}, {30'd0, e.dt});
                if (e.mwe) chk("rnd_wdata", mem_wdata, e.d);
            end
            if (e.rvalid != 0) chk("rnd_rdata", rdata, e.rd);
            for (int i = 0; i < 2; i++) begin
                if (e.gnt[i]) p_pend[i] = 1'b0;
                if (!p_pend[i] && $urandom_range(1, 0) == 1) begin
                    p_pend[i] = 1'b1;
                    p_we[i]   = 1'($urandom_range(1, 0));
                    p_addr[i] = 6'($urandom_range(63, 0));
                    p_data[i] = $urandom;
                    p_dt[i]   = 2'($urandom_range(2, 0));
                end
            end
            req = {p_pend[1], p_pend[0]};
            we = {p_we[1], p_we[0]};
            addr0 = p_addr[0]; addr1 = p_addr[1];
            wdata0 = p_data[0]; wdata1 = p_data[1];
            dtype0 = p_dt[0]; dtype1 = p_dt[1];
            if (e.gnt == 0 && e.rvalid == 0 && exp_q.size() == 0 && (p_pend[0] || p_pend[1])) begin
                if (p_pend[0] && p_pend[1]) w = (last == 0) ? 1 : 0;
                else w = p_pend[1] ? 1 : 0;
                last = w;
                exp_q.push_back('{(w == 1) ? 2'b10 : 2'b01, 2'b00, p_we[w], !p_we[w],
                                  p_addr[w], p_data[w], p_dt[w], 32'h0});
                if (p_we[w]) ref_mem[p_addr[w]] = p_data[w];
                else exp_q.push_back('{2'b00, (w == 1) ? 2'b10 : 2'b01, 1'b0, 1'b0,
                                       6'h0, 32'h0, 2'b00, ref_mem[p_addr[w]]});
            end
            @(negedge clk);
        end
        req = 2'b00;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
